// File: rtl/des_iter_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : des_iter_ctrl
// Brief   : Iterative DES sequencer. Holds L/R, C/D and the round count, and
//           runs one Feistel round per clock against an external f datapath.
// Rev     : 1.0  initial release
// ============================================================================
module des_iter_ctrl #(
    parameter int ROUNDS = 16,
    parameter int HALF_W = 28
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  decrypt,
    input  logic [63:0]           data_in,
    input  logic [2*HALF_W-1:0]   key_cd,
    input  logic [31:0]           f_res,
    output logic [31:0]           r_cur,
    output logic [2*HALF_W-1:0]   cd_cur,
    output logic                  busy,
    output logic                  done,
    output logic [63:0]           data_out
);

    localparam logic [4:0] LAST_RND = 5'(ROUNDS);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ROUND  = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [31:0]           l_q, l_d;
    logic [31:0]           r_q, r_d;
    logic [2*HALF_W-1:0]   cd_q, cd_d;
    logic [2*HALF_W-1:0]   cd_rot;
    logic [4:0]            rnd_q, rnd_d;
    logic                  mode_q, mode_d;
    logic                  done_q, done_d;
    logic [63:0]           dout_q, dout_d;
    logic [1:0]            rot_amt;

    function automatic logic [HALF_W-1:0] rot_half(
        input logic [HALF_W-1:0] x,
        input logic [1:0]        amt,
        input logic              right
    );
        logic [HALF_W-1:0] y;
        case ({right, amt})
            3'b001:  y = {x[HALF_W-2:0], x[HALF_W-1]};
            3'b010:  y = {x[HALF_W-3:0], x[HALF_W-1:HALF_W-2]};
            3'b101:  y = {x[0], x[HALF_W-1:1]};
            3'b110:  y = {x[1:0], x[HALF_W-1:2]};
            default: y = x;
        endcase
        return y;
    endfunction

    // Decrypt walks the encrypt schedule backwards, so its first round sees
    // the untouched key (which equals K16 after a full 28-bit rotation).
    always_comb begin
        rot_amt = 2'd2;
        if (mode_q && (rnd_q == 5'd1)) begin
            rot_amt = 2'd0;
        end else if ((rnd_q == 5'd1) || (rnd_q == 5'd2) ||
                     (rnd_q == 5'd9) || (rnd_q == LAST_RND)) begin
            rot_amt = 2'd1;
        end
    end

    assign cd_rot = {rot_half(cd_q[2*HALF_W-1:HALF_W], rot_amt, mode_q),
                     rot_half(cd_q[HALF_W-1:0],        rot_amt, mode_q)};

    always_comb begin
        state_d = state_q;
        l_d     = l_q;
        r_d     = r_q;
        cd_d    = cd_q;
        rnd_d   = rnd_q;
        mode_d  = mode_q;
        dout_d  = dout_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    l_d     = data_in[63:32];
                    r_d     = data_in[31:0];
                    cd_d    = key_cd;
                    mode_d  = decrypt;
                    rnd_d   = 5'd1;
                    state_d = S_ROUND;
                end
            end
            S_ROUND: begin
                cd_d  = cd_rot;
                l_d   = r_q;
                r_d   = l_q ^ f_res;
                rnd_d = rnd_q + 5'd1;
                if (rnd_q == LAST_RND) begin
                    state_d = S_FINISH;
                end
            end
            S_FINISH: begin
                dout_d  = {r_q, l_q};
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            l_q     <= '0;
            r_q     <= '0;
            cd_q    <= '0;
            rnd_q   <= '0;
            mode_q  <= 1'b0;
            done_q  <= 1'b0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            l_q     <= l_d;
            r_q     <= r_d;
            cd_q    <= cd_d;
            rnd_q   <= rnd_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
            dout_q  <= dout_d;
        end
    end

    assign r_cur    = r_q;
    assign cd_cur   = (state_q == S_ROUND) ? cd_rot : cd_q;
    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;
    assign data_out = dout_q;

endmodule
`default_nettype wire
